// File: rtl/rpn_stack_controller.sv
// ---------------------------------------------------------------------------
// rpn_stack_controller
//
// Sequencer for the calculator's RPN operand stack and the ALU. It holds a
// DEPTH-entry stack of WIDTH-bit registers (one load enable per entry) and
// executes PUSH / POP / OPERATE / CLEAR commands. OPERATE pops the two top
// operands, runs the ALU through a start/done handshake and pushes the result.
//
// Optional feature macro: RPN_ALU_TIMEOUT_EN
//   When defined, an 8-bit counter runs in WAIT. If ALU_DONE is not seen
//   within 255 cycles of entering WAIT, the operation is abandoned (stack and
//   COUNT untouched) and the sticky ERR_TIMEOUT output is set.
//
// Ports:
//   CLOCK, RESET         rising-edge clock, synchronous active-low reset
//   CMD_VALID/CMD_READY  command handshake
//   CMD                  00 PUSH, 01 POP, 10 OPERATE, 11 CLEAR
//   OPCODE               ALU operation, sampled with OPERATE
//   DATA_IN              value for PUSH
//   ALU_A / ALU_B        operands (A = second-from-top, B = top)
//   ALU_OP               latched OPCODE
//   ALU_START            one-cycle start pulse (ISSUE state)
//   ALU_DONE/ALU_RESULT  ALU completion and result
//   TOP                  stack[COUNT-1], 0 when empty (drives the display)
//   COUNT                number of valid entries
//   ERR_OVERFLOW         sticky, PUSH on a full stack
//   ERR_UNDERFLOW        sticky, POP on empty / OPERATE with fewer than 2
//   ERR_TIMEOUT          sticky ALU timeout (only with RPN_ALU_TIMEOUT_EN)
//   dbg_state            current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
// ---------------------------------------------------------------------------
module rpn_stack_controller #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [2:0]       ALU_OP,
    output logic             ALU_START,
    input  logic             ALU_DONE,
    input  logic [WIDTH-1:0] ALU_RESULT,
    output logic [WIDTH-1:0] TOP,
    output logic [CNT_W-1:0] COUNT,
    output logic             ERR_OVERFLOW,
    output logic             ERR_UNDERFLOW,
`ifdef RPN_ALU_TIMEOUT_EN
    output logic             ERR_TIMEOUT,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_PUSH    = 2'b00;
    localparam logic [1:0] CMD_POP     = 2'b01;
    localparam logic [1:0] CMD_OPERATE = 2'b10;
    localparam logic [1:0] CMD_CLEAR   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DEPTH-1:0] stack_we;
    logic [WIDTH-1:0] stack_wdata;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
`ifdef RPN_ALU_TIMEOUT_EN
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             err_tmo_q, err_tmo_d;
`endif

    logic             cmd_fire;
    logic [WIDTH-1:0] top_val;   // stack[count-1]
    logic [WIDTH-1:0] next_val;  // stack[count-2]

    // Handshake: a command transfers on a rising edge where CMD_VALID and
    // CMD_READY are both 1. CMD_READY depends only on the state (IDLE), never
    // on CMD_VALID; a source seeing CMD_READY=0 must hold its command.
    assign CMD_READY = (state_q == S_IDLE);
    assign cmd_fire  = CMD_VALID && (state_q == S_IDLE);

    // Read muxes by count compare; avoids indexing with a wider count value.
    always_comb begin
        top_val  = '0;
        next_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) top_val  = stack_q[i];
            if (count_q == CNT_W'(i + 2)) next_val = stack_q[i];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        stack_we    = '0;
        stack_wdata = '0;
`ifdef RPN_ALU_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_tmo_d   = err_tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (CMD)
                        CMD_PUSH: begin
                            if (count_q < CNT_FULL) begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (count_q == CNT_W'(i)) stack_we[i] = 1'b1;
                                end
                                stack_wdata = DATA_IN;
                                count_d     = count_q + CNT_ONE;
                            end else begin
                                err_ovf_d = 1'b1;
                            end
                        end
                        CMD_POP: begin
                            // The freed entry keeps its value; only COUNT moves.
                            if (count_q != '0) count_d   = count_q - CNT_ONE;
                            else               err_unf_d = 1'b1;
                        end
                        CMD_OPERATE: begin
                            if (count_q < CNT_TWO) begin
                                err_unf_d = 1'b1;
                            end else begin
                                alu_a_d  = next_val;
                                alu_b_d  = top_val;
                                alu_op_d = OPCODE;
                                state_d  = S_ISSUE;
                            end
                        end
                        CMD_CLEAR: begin
                            count_d     = '0;
                            stack_we    = '1;
                            stack_wdata = '0;
                            err_ovf_d   = 1'b0;
                            err_unf_d   = 1'b0;
`ifdef RPN_ALU_TIMEOUT_EN
                            err_tmo_d   = 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                // ALU_START is high for this single cycle; ALU_DONE is not
                // looked at until WAIT.
                state_d = S_WAIT;
`ifdef RPN_ALU_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (ALU_DONE) begin
                    // Result replaces the older operand; the top slot is freed.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_q == CNT_W'(i + 2)) stack_we[i] = 1'b1;
                    end
                    stack_wdata = ALU_RESULT;
                    count_d     = count_q - CNT_ONE;
                    state_d     = S_IDLE;
                end
`ifdef RPN_ALU_TIMEOUT_EN
                // Edge k of WAIT (k = 1, 2, ...) sees tmo_cnt_q = k-1, so
                // the 255th WAIT edge without ALU_DONE gives up.
                else if (tmo_cnt_q == 8'd254) begin
                    state_d   = S_IDLE;
                    err_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_we[i] ? stack_wdata : stack_q[i];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
`ifdef RPN_ALU_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
`ifdef RPN_ALU_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
`endif
        end
    end

    assign ALU_A         = alu_a_q;
    assign ALU_B         = alu_b_q;
    assign ALU_OP        = alu_op_q;
    assign ALU_START     = (state_q == S_ISSUE);
    assign TOP           = top_val;
    assign COUNT         = count_q;
    assign ERR_OVERFLOW  = err_ovf_q;
    assign ERR_UNDERFLOW = err_unf_q;
`ifdef RPN_ALU_TIMEOUT_EN
    assign ERR_TIMEOUT   = err_tmo_q;
`endif
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_controller
//
// Self-checking bench for rpn_stack_controller (WIDTH=8, DEPTH=4). A queue
// based model of the RPN stack is advanced on every rising edge from the
// inputs; a compare process checks every output against it on each falling
// edge. Directed sequences add literal expectations, followed by randomized
// command traffic with random ALU latencies and spurious ALU_DONE pulses.
// ---------------------------------------------------------------------------
module tb_rpn_stack_controller;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    localparam logic [1:0] C_PUSH = 2'b00;
    localparam logic [1:0] C_POP  = 2'b01;
    localparam logic [1:0] C_OPER = 2'b10;
    localparam logic [1:0] C_CLR  = 2'b11;

    // ---------------- clock / reset / DUT ----------------
    logic             CLOCK      = 1'b0;
    logic             RESET      = 1'b0;
    logic             CMD_VALID  = 1'b0;
    logic [1:0]       CMD        = 2'b00;
    logic [2:0]       OPCODE     = 3'b000;
    logic [WIDTH-1:0] DATA_IN    = '0;
    logic             ALU_DONE   = 1'b0;
    logic [WIDTH-1:0] ALU_RESULT = '0;
    logic             CMD_READY;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [2:0]       ALU_OP;
    logic             ALU_START;
    logic [WIDTH-1:0] TOP;
    logic [CNT_W-1:0] COUNT;
    logic             ERR_OVERFLOW;
    logic             ERR_UNDERFLOW;
`ifdef RPN_ALU_TIMEOUT_EN
    logic             ERR_TIMEOUT;
`endif
    logic [1:0]       dbg_state;

    always #5 CLOCK = ~CLOCK;

    rpn_stack_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD          (CMD),
        .OPCODE       (OPCODE),
        .DATA_IN      (DATA_IN),
        .ALU_A        (ALU_A),
        .ALU_B        (ALU_B),
        .ALU_OP       (ALU_OP),
        .ALU_START    (ALU_START),
        .ALU_DONE     (ALU_DONE),
        .ALU_RESULT   (ALU_RESULT),
        .TOP          (TOP),
        .COUNT        (COUNT),
        .ERR_OVERFLOW (ERR_OVERFLOW),
        .ERR_UNDERFLOW(ERR_UNDERFLOW),
`ifdef RPN_ALU_TIMEOUT_EN
        .ERR_TIMEOUT  (ERR_TIMEOUT),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit aborted  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_stk holds the valid entries, oldest first. m_phase: 0 idle,
    // 1 start-pulse cycle, 2 waiting for the ALU.
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit m_tmo = 1'b0;
    int m_phase = 0;
    int m_a = 0;
    int m_b = 0;
    int m_op = 0;
    int m_wait = 0;

    initial begin
        forever begin
            @(posedge CLOCK);
            if (!RESET) begin
                m_stk.delete();
                m_ovf = 0; m_unf = 0; m_tmo = 0;
                m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_wait = 0;
            end else if (m_phase == 0) begin
                if (CMD_VALID) begin
                    case (CMD)
                        C_PUSH: if (m_stk.size() < DEPTH) m_stk.push_back(int'(DATA_IN));
                                else m_ovf = 1;
                        C_POP:  if (m_stk.size() > 0) void'(m_stk.pop_back());
                                else m_unf = 1;
                        C_OPER: if (m_stk.size() < 2) m_unf = 1;
                                else begin
                                    m_a = m_stk[m_stk.size() - 2];
                                    m_b = m_stk[m_stk.size() - 1];
                                    m_op = int'(OPCODE);
                                    m_phase = 1;
                                end
                        default: begin
                            m_stk.delete();
                            m_ovf = 0; m_unf = 0; m_tmo = 0;
                        end
                    endcase
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_wait = 0;
            end else begin
                if (ALU_DONE) begin
                    void'(m_stk.pop_back());
                    m_stk[m_stk.size() - 1] = int'(ALU_RESULT);
                    m_phase = 0;
                end else begin
                    m_wait++;
`ifdef RPN_ALU_TIMEOUT_EN
                    if (m_wait == 255) begin
                        m_phase = 0;
                        m_tmo = 1;
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge CLOCK);
        forever begin
            @(negedge CLOCK);
            check("count", 32'(COUNT), m_stk.size());
            check("top", 32'(TOP), (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1]);
            check("cmd_ready", 32'(CMD_READY), 32'(m_phase == 0));
            check("alu_start", 32'(ALU_START), 32'(m_phase == 1));
            check("alu_a", 32'(ALU_A), m_a);
            check("alu_b", 32'(ALU_B), m_b);
            check("alu_op", 32'(ALU_OP), m_op);
            check("err_overflow", 32'(ERR_OVERFLOW), 32'(m_ovf));
            check("err_underflow", 32'(ERR_UNDERFLOW), 32'(m_unf));
`ifdef RPN_ALU_TIMEOUT_EN
            check("err_timeout", 32'(ERR_TIMEOUT), 32'(m_tmo));
`endif
        end
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic send(input logic [1:0] c, input logic [2:0] op, input logic [7:0] d);
        int guard;
        if (aborted) return;
        CMD_VALID = 1'b1; CMD = c; OPCODE = op; DATA_IN = d;
        guard = 0;
        while (CMD_READY !== 1'b1 && guard < 400) begin
            @(negedge CLOCK);
            guard++;
        end
        if (guard >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: CMD_READY=%b after 400 cycles, expected 1", CMD_READY);
            aborted = 1'b1;
        end
        @(negedge CLOCK);
        CMD_VALID = 1'b0;
    endtask

    // OPERATE with an ALU that answers 'delay' cycles after the start pulse
    // (delay=3 puts ALU_DONE on edge T+4). Busy-time command noise and an
    // ISSUE-cycle ALU_DONE must both be ignored.
    task automatic operate(input logic [2:0] op, input int delay, input logic [7:0] res);
        send(C_OPER, op, 8'h00);
        if (aborted || ALU_START !== 1'b1) return;
        if ($urandom_range(0, 3) == 0) begin
            ALU_DONE = 1'b1;
            ALU_RESULT = 8'($urandom);
        end
        repeat (delay) begin
            @(negedge CLOCK);
            ALU_DONE  = 1'b0;
            CMD_VALID = 1'($urandom_range(0, 1));
            CMD       = 2'($urandom);
            DATA_IN   = 8'($urandom);
        end
        ALU_DONE = 1'b1;
        ALU_RESULT = res;
        @(negedge CLOCK);
        ALU_DONE = 1'b0;
        CMD_VALID = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int waits;
        int r;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        check("lit_reset_count", 32'(COUNT), 0);
        check("lit_reset_top", 32'(TOP), 0);
        check("lit_reset_ready", 32'(CMD_READY), 1);

        // PUSH 5, PUSH 3
        send(C_PUSH, 3'd0, 8'h05);
        send(C_PUSH, 3'd0, 8'h03);
        check("lit_push_count", 32'(COUNT), 2);
        check("lit_push_top", 32'(TOP), 8'h03);

        // 5 3 OP(001), ALU_DONE on edge T+4 with result 2
        send(C_OPER, 3'd1, 8'h00);
        check("lit_op_start", 32'(ALU_START), 1);
        check("lit_op_a", 32'(ALU_A), 8'h05);
        check("lit_op_b", 32'(ALU_B), 8'h03);
        check("lit_op_opcode", 32'(ALU_OP), 3'b001);
        repeat (3) begin
            @(negedge CLOCK);
            check("lit_op_start_low", 32'(ALU_START), 0);
        end
        ALU_DONE = 1'b1; ALU_RESULT = 8'h02;
        @(negedge CLOCK);
        ALU_DONE = 1'b0;
        check("lit_op_count", 32'(COUNT), 1);
        check("lit_op_top", 32'(TOP), 8'h02);
        check("lit_op_ready", 32'(CMD_READY), 1);

        // Overflow: five pushes into a 4-deep stack, then POP
        send(C_CLR, 3'd0, 8'h00);
        for (int i = 0; i < 5; i++) send(C_PUSH, 3'd0, 8'(8'h11 + i));
        check("lit_ovf_count", 32'(COUNT), 4);
        check("lit_ovf_top", 32'(TOP), 8'h14);
        check("lit_ovf_flag", 32'(ERR_OVERFLOW), 1);
        send(C_POP, 3'd0, 8'h00);
        check("lit_ovf_pop_count", 32'(COUNT), 3);
        check("lit_ovf_pop_top", 32'(TOP), 8'h13);

        // Underflow: POP on empty, OPERATE with one entry, then CLEAR
        send(C_CLR, 3'd0, 8'h00);
        send(C_POP, 3'd0, 8'h00);
        check("lit_unf_flag_pop", 32'(ERR_UNDERFLOW), 1);
        send(C_PUSH, 3'd0, 8'h07);
        operate(3'd2, 2, 8'hEE);
        check("lit_unf_count", 32'(COUNT), 1);
        check("lit_unf_top", 32'(TOP), 8'h07);
        check("lit_unf_flag_op", 32'(ERR_UNDERFLOW), 1);
        send(C_CLR, 3'd0, 8'h00);
        check("lit_clr_ovf", 32'(ERR_OVERFLOW), 0);
        check("lit_clr_unf", 32'(ERR_UNDERFLOW), 0);
        check("lit_clr_count", 32'(COUNT), 0);
        check("lit_clr_top", 32'(TOP), 0);

        // Reset while waiting on the ALU, then a late ALU_DONE
        send(C_PUSH, 3'd0, 8'h31);
        send(C_PUSH, 3'd0, 8'h32);
        send(C_OPER, 3'd4, 8'h00);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        ALU_DONE = 1'b1; ALU_RESULT = 8'h99;
        @(negedge CLOCK);
        ALU_DONE = 1'b0;
        check("lit_rst_count", 32'(COUNT), 0);
        check("lit_rst_top", 32'(TOP), 0);
        check("lit_rst_ready", 32'(CMD_READY), 1);

`ifdef RPN_ALU_TIMEOUT_EN
        // ALU never answers: controller gives up 255 cycles after entering WAIT
        send(C_PUSH, 3'd0, 8'h21);
        send(C_PUSH, 3'd0, 8'h22);
        send(C_OPER, 3'd5, 8'h00);
        waits = 0;
        while (CMD_READY !== 1'b1 && waits < 400) begin
            @(negedge CLOCK);
            waits++;
        end
        check("lit_tmo_cycles", waits, 256);
        check("lit_tmo_flag", 32'(ERR_TIMEOUT), 1);
        check("lit_tmo_count", 32'(COUNT), 2);
        check("lit_tmo_top", 32'(TOP), 8'h22);
        send(C_POP, 3'd0, 8'h00);
        check("lit_tmo_below", 32'(TOP), 8'h21);
        send(C_CLR, 3'd0, 8'h00);
        check("lit_tmo_clr", 32'(ERR_TIMEOUT), 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 300 && !aborted; n++) begin
            r = $urandom_range(0, 19);
            if (r < 8) begin
                ALU_DONE = 1'($urandom_range(0, 1));
                ALU_RESULT = 8'($urandom);
                send(C_PUSH, 3'($urandom), 8'($urandom));
                ALU_DONE = 1'b0;
            end else if (r < 12) begin
                send(C_POP, 3'd0, 8'($urandom));
            end else if (r < 19) begin
                operate(3'($urandom), $urandom_range(1, 6), 8'($urandom));
            end else begin
                send(C_CLR, 3'd0, 8'h00);
            end
        end

        repeat (2) @(negedge CLOCK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
